button_press_counter: RTL and testbench
=======================================

// Module: button_press_counter
// PURPOSE
//   Input-side companion to the LED drivers. It reads one raw board pushbutton
//   and passes it through a 2-FF synchronizer, then a counter-based debouncer.
//   It produces a debounced level, one-cycle press/release strobes, and an
//   8-bit wrapping press count that drives LED7..LED0 at top level.
//   The whole block runs in the 12 MHz CLK domain.
// PARAMETERS
//   DEBOUNCE_CYCLES  120000  cycles the synchronized input must stay stable before
//                            it is accepted (10 ms at 12 MHz); legal range >= 2
//   ACTIVE_LOW       0       1: BTN is inverted at the input (pressed = 0 on pin)
//   CNT_W (local)            $clog2(DEBOUNCE_CYCLES), width of debounce counter
// PORTS
//   CLK      in   1  12 MHz system clock; all state on rising edge
//   RST      in   1  reset: asynchronous, active-high
//   BTN      in   1  raw pushbutton pin; asynchronous, bouncy
//   PRESSED  out  1  debounced button level (1 = pressed)
//   PRESS    out  1  one-cycle strobe on accepted 0->1 of PRESSED
//   RELEASE  out  1  one-cycle strobe on accepted 1->0 of PRESSED
//   COUNT    out  8  number of accepted presses, modulo 256
// BEHAVIOUR
//   Reset (async, RST=1)
//     - sync1, sync2, PRESSED, PRESS, RELEASE and the debounce counter all go to 0.
//     - COUNT = 8'd0. Outputs stay 0 while RST is high.
//     - Synchronizer resets to the not-pressed value after ACTIVE_LOW inversion.
//   Synchronizer: b = BTN ^ ACTIVE_LOW; sync1 <= b; sync2 <= sync1. No logic
//     reads sync1.
//   Debounce, every edge:
//     - If sync2 == PRESSED: cnt <= 0.
//     - Else if cnt == DEBOUNCE_CYCLES-1: PRESSED <= sync2; cnt <= 0.
//     - Else: cnt <= cnt + 1.
//   Strobes are registered and update on the same edge as PRESSED:
//     - PRESS   = accept && sync2 == 1.
//     - RELEASE = accept && sync2 == 0.
//     - Both are high for exactly one cycle and are never high together.
//   Latency: BTN changes cleanly before edge 0 -> PRESSED/PRESS are visible
//     after edge DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 edges in total.
//   Glitches: any excursion of sync2 back to PRESSED before acceptance clears
//     cnt. The full DEBOUNCE_CYCLES window then restarts on the next change,
//     so bounces shorter than the window never toggle PRESSED.
//   COUNT <= COUNT + 1 on PRESS. It wraps 255 -> 0 silently; RELEASE does not
//     change COUNT.
//   Button held through reset release: this is treated as a new press. PRESS
//     fires DEBOUNCE_CYCLES+2 edges after RST falls and COUNT becomes 1.
//   Reset mid-debounce: cnt is discarded, no strobe is issued, and the partial
//     window is not resumed.
//   cnt never exceeds DEBOUNCE_CYCLES-1, so there is no counter overflow.
// TESTING (bench uses DEBOUNCE_CYCLES=4, ACTIVE_LOW=0 unless stated)
//   1 Reset: RST=1 with BTN toggling -> PRESSED=PRESS=RELEASE=0, COUNT=0
//     throughout. This holds even mid-cycle with no CLK edge.
//   2 Clean press: BTN 0->1 before edge 0 -> PRESS=1 only in the cycle after
//     edge 5, PRESSED=1 from then, COUNT=1.
//   3 Bounce: BTN pulses high for 3 cycles, low for 1, then holds high ->
//     - no PRESS during the bounce;
//     - exactly one PRESS 6 edges after the final rise;
//     - COUNT=1.
//   4 Release: from pressed, BTN 1->0 -> RELEASE one cycle after edge 5,
//     PRESSED=0, COUNT unchanged.
//   5 Wrap: 256 clean press/release pairs -> COUNT reads 255 then 0. Exactly
//     256 PRESS and 256 RELEASE strobes occur.
//   6 Held through reset, ACTIVE_LOW=1: BTN=0 (pressed) while RST falls ->
//     PRESS 6 edges after RST falls, COUNT=1.

Source files
------------

// File: rtl/button_press_counter.sv
// Pushbutton front end: 2-FF synchronizer, counter debouncer, press/release
// strobes and an 8-bit wrapping press count for the LED bank.
module button_press_counter #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN,
  output logic       PRESSED,
  output logic       PRESS,
  output logic       RELEASE,
  output logic [7:0] COUNT
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             btn_norm_s;
  logic             sync1_r;
  logic             sync2_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             accept_s;

  // Normalise polarity so that 1 always means pressed downstream.
  always_comb begin
    btn_norm_s = BTN ^ ACTIVE_LOW;
  end

  // Two-flop synchronizer; sync1_r is metastability settling only.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn_norm_s;
      sync2_r <= sync1_r;
    end
  end

  // Debounce next-state: any return to the accepted level restarts the window.
  always_comb begin
    accept_s  = 1'b0;
    cnt_nxt_s = {CNT_W{1'b0}};
    if (sync2_r == PRESSED) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (cnt_r == CNT_MAX) begin
      accept_s  = 1'b1;
      cnt_nxt_s = {CNT_W{1'b0}};
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end
  end

  // Debounce counter register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  // Registered level, strobes and press count, all updated on acceptance.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PRESSED <= 1'b0;
      PRESS   <= 1'b0;
      RELEASE <= 1'b0;
      COUNT   <= 8'd0;
    end else begin
      PRESS   <= accept_s & sync2_r;
      RELEASE <= accept_s & ~sync2_r;
      if (accept_s) begin
        PRESSED <= sync2_r;
        if (sync2_r) begin
          COUNT <= COUNT + 8'd1;
        end else begin
          COUNT <= COUNT;
        end
      end else begin
        PRESSED <= PRESSED;
        COUNT   <= COUNT;
      end
    end
  end

endmodule

// File: tb/tb_button_press_counter.sv
// Directed bench for button_press_counter with DEBOUNCE_CYCLES=4; a second
// ACTIVE_LOW instance covers the button held through reset release.
module tb_button_press_counter;

  logic       CLK;
  logic       RST;
  logic       BTN;
  logic       PRESSED;
  logic       PRESS;
  logic       RELEASE;
  logic [7:0] COUNT;

  logic       rst_al;
  logic       btn_al;
  logic       pressed_al;
  logic       press_al;
  logic       release_al;
  logic [7:0] count_al;

  int checks = 0;
  int errors = 0;

  button_press_counter #(.DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b0)) dut (
    .CLK(CLK), .RST(RST), .BTN(BTN),
    .PRESSED(PRESSED), .PRESS(PRESS), .RELEASE(RELEASE), .COUNT(COUNT)
  );

  button_press_counter #(.DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b1)) dut_al (
    .CLK(CLK), .RST(rst_al), .BTN(btn_al),
    .PRESSED(pressed_al), .PRESS(press_al), .RELEASE(release_al), .COUNT(count_al)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // BTN has just changed at a negedge; the next posedge is edge 0 and the
  // accept lands on edge 5, sampled at the negedge after it.
  task automatic check_accept(input string tag, input bit is_press, input logic [7:0] exp_cnt);
    for (int k = 0; k <= 6; k++) begin
      @(negedge CLK);
      check_eq({tag, "_press"},   PRESS,   (is_press && k == 5) ? 32'd1 : 32'd0);
      check_eq({tag, "_release"}, RELEASE, (!is_press && k == 5) ? 32'd1 : 32'd0);
      check_eq({tag, "_level"},   PRESSED, (k >= 5) ? {31'd0, is_press} : {31'd0, !is_press});
    end
    check_eq({tag, "_count"}, COUNT, {24'd0, exp_cnt});
  endtask

  int n_press;
  int n_release;
  int n_both;

  initial begin
    RST    = 1'b0;
    BTN    = 1'b0;
    rst_al = 1'b1;
    btn_al = 1'b1;
    #1;
    RST = 1'b1;

    // 1: reset holds outputs low with BTN toggling, including mid-cycle
    for (int i = 0; i < 12; i++) begin
      #3 BTN = ~BTN;
      check_eq("rst_pressed", PRESSED, 32'd0);
      check_eq("rst_strobes", {PRESS, RELEASE}, 32'd0);
      check_eq("rst_count", COUNT, 32'd0);
    end
    BTN = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    check_eq("idle_pressed", PRESSED, 32'd0);

    // 2: clean press
    BTN = 1'b1;
    check_accept("press", 1'b1, 8'd1);

    // 4: release keeps COUNT
    BTN = 1'b0;
    check_accept("release", 1'b0, 8'd1);

    // 3: bounce high 3, low 1, then hold high
    do_reset();
    check_eq("bounce_rst_count", COUNT, 32'd0);
    n_press = 0;
    BTN = 1'b1;
    for (int e = 0; e <= 10; e++) begin
      @(negedge CLK);
      if (e == 2) BTN = 1'b0;
      if (e == 3) BTN = 1'b1;
      if (PRESS) n_press++;
      check_eq("bounce_press", PRESS, (e == 9) ? 32'd1 : 32'd0);
      check_eq("bounce_level", PRESSED, (e >= 9) ? 32'd1 : 32'd0);
    end
    check_eq("bounce_npress", n_press, 32'd1);
    check_eq("bounce_count", COUNT, 32'd1);

    // async reset mid-cycle with no clock edge
    @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    check_eq("async_pressed", PRESSED, 32'd0);
    check_eq("async_count", COUNT, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    BTN = 1'b0;
    repeat (3) @(negedge CLK);

    // reset mid-debounce discards the partial window; held button re-presses
    BTN = 1'b1;
    repeat (4) @(negedge CLK);
    check_eq("mid_prelevel", PRESSED, 32'd0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    check_eq("mid_rst_press", PRESS, 32'd0);
    RST = 1'b0;
    check_accept("mid_rst", 1'b1, 8'd1);

    // 5: 256 press/release pairs wrap COUNT
    BTN = 1'b0;
    do_reset();
    n_press   = 0;
    n_release = 0;
    n_both    = 0;
    for (int p = 0; p < 256; p++) begin
      BTN = 1'b1;
      repeat (8) begin
        @(negedge CLK);
        if (PRESS) n_press++;
        if (RELEASE) n_release++;
        if (PRESS && RELEASE) n_both++;
      end
      BTN = 1'b0;
      repeat (8) begin
        @(negedge CLK);
        if (PRESS) n_press++;
        if (RELEASE) n_release++;
        if (PRESS && RELEASE) n_both++;
      end
      if (p == 254) check_eq("wrap_255", COUNT, 32'd255);
    end
    check_eq("wrap_0", COUNT, 32'd0);
    check_eq("wrap_npress", n_press, 32'd256);
    check_eq("wrap_nrelease", n_release, 32'd256);
    check_eq("wrap_both", n_both, 32'd0);

    // 6: ACTIVE_LOW, pin low (pressed) while reset falls
    btn_al = 1'b0;
    repeat (2) @(negedge CLK);
    check_eq("al_rst_pressed", pressed_al, 32'd0);
    check_eq("al_rst_count", count_al, 32'd0);
    rst_al = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      @(negedge CLK);
      check_eq("al_press", press_al, (k == 5) ? 32'd1 : 32'd0);
      check_eq("al_release", release_al, 32'd0);
      check_eq("al_level", pressed_al, (k >= 5) ? 32'd1 : 32'd0);
    end
    check_eq("al_count", count_al, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
